// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared widths, pipeline stage type and saturating step helper
//
// Purpose: constants and helpers shared by the prediction chooser and its
// chooser table. No ports (package).
package bp_pkg;

  localparam int JSCW_DEFAULT = 2;  // HP/LP counter width
  localparam int CIW_DEFAULT  = 8;  // log2 chooser table depth
  localparam int CCW_DEFAULT  = 2;  // chooser counter width
  localparam logic [CCW_DEFAULT-1:0] CHOOSER_INIT_DEFAULT = 2'b10;  // weakly HP

  // Working width of sat_step; covers the chooser entries and the 16-bit
  // mispredict counter alike.
  localparam int SAT_W = 32;

  // One IF/ID/EX pipeline slot.
  typedef struct packed {
    logic hp_taken;
    logic lp_taken;
    logic sel;       // 1: prediction came from HP
    logic pred;
    logic valid;
  } stage_t;

  // Saturating +1 (up = 1) or -1 (up = 0) for a counter that occupies the
  // low 'width' bits of 'count'.
  function automatic logic [SAT_W-1:0] sat_step(input logic [SAT_W-1:0] count,
                                                input logic             up,
                                                input int unsigned      width);
    logic [SAT_W-1:0] max_val;
    max_val = {SAT_W{1'b1}} >> (SAT_W - width);
    if (up) begin
      return (count == max_val) ? count : count + SAT_W'(1);
    end
    return (count == '0) ? count : count - SAT_W'(1);
  endfunction

endpackage

// File: rtl/chooser_table.sv
// rtl/chooser_table.sv - flop-array chooser table, one read port, one saturating update port
//
// Purpose: holds one saturating chooser counter per table index.
// Ports:
//   clk, rst_n : clock, async active-low reset (all entries -> INIT_VALUE)
//   rd_idx     : combinational read index
//   rd_data    : entry at rd_idx (pre-update value during a same-index write)
//   wr_en      : apply a saturating step to entry wr_idx at the clock edge
//   wr_idx     : update index
//   wr_up      : 1 = step toward HP (+1), 0 = step toward LP (-1)
module chooser_table
  import bp_pkg::*;
#(
  parameter int INDEX_WIDTH   = CIW_DEFAULT,
  parameter int COUNTER_WIDTH = CCW_DEFAULT,
  parameter logic [COUNTER_WIDTH-1:0] INIT_VALUE = CHOOSER_INIT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [INDEX_WIDTH-1:0]   rd_idx,
  output logic [COUNTER_WIDTH-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [INDEX_WIDTH-1:0]   wr_idx,
  input  logic                     wr_up
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [COUNTER_WIDTH-1:0] entry_q [DEPTH];
  logic [COUNTER_WIDTH-1:0] next_entry;

  assign rd_data    = entry_q[rd_idx];
  assign next_entry = COUNTER_WIDTH'(sat_step(SAT_W'(entry_q[wr_idx]), wr_up, COUNTER_WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= INIT_VALUE;
      end
    end else if (wr_en) begin
      entry_q[wr_idx] <= next_entry;
    end
  end

endmodule

// File: rtl/prediction_chooser.sv
// rtl/prediction_chooser.sv - tournament chooser between global (HP) and local (LP) predictors
//
// Purpose: picks HP or LP per PC in IF, carries the three predictions to EX,
// flags mispredictions there and trains the chooser from the resolved outcome.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   PL_stall           : hold ID/EX registers, table and counter
//   flush              : kill ID and EX entries at the next edge (beats stall)
//   pc, pc_ex          : IF read PC / EX update PC
//   HP_count, LP_count : predictor counters for pc (MSB = taken)
//   resolve_en         : EX instruction is a conditional branch resolved now
//   branch_taken       : actual outcome
//   predict_taken      : IF prediction (combinational)
//   predict_taken_ex   : prediction carried to EX
//   select_hp_ex       : EX prediction came from HP
//   mispredict_ex      : valid resolved EX branch whose prediction was wrong
//   mispredict_cnt     : saturating mispredict count
module prediction_chooser
  import bp_pkg::*;
#(
  parameter int JUMP_STATUS_COUNTER_WIDTH = JSCW_DEFAULT,
  parameter int CHOOSER_INDEX_WIDTH       = CIW_DEFAULT,
  parameter int CHOOSER_COUNTER_WIDTH     = CCW_DEFAULT,
  parameter logic [CHOOSER_COUNTER_WIDTH-1:0] CHOOSER_INIT_VALUE = CHOOSER_INIT_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 PL_stall,
  input  logic                                 flush,
  input  logic [31:0]                          pc,
  input  logic [31:0]                          pc_ex,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] HP_count,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LP_count,
  input  logic                                 resolve_en,
  input  logic                                 branch_taken,
  output logic                                 predict_taken,
  output logic                                 predict_taken_ex,
  output logic                                 select_hp_ex,
  output logic                                 mispredict_ex,
  output logic [15:0]                          mispredict_cnt
);

  logic [CHOOSER_INDEX_WIDTH-1:0]   rd_idx;
  logic [CHOOSER_INDEX_WIDTH-1:0]   wr_idx;
  logic [CHOOSER_COUNTER_WIDTH-1:0] rd_entry;
  logic                             hp_msb;
  logic                             lp_msb;
  logic                             sel_if;
  stage_t                           if_s;
  stage_t                           id_q;
  stage_t                           ex_q;
  logic                             ex_active;
  logic                             hp_ok;
  logic                             lp_ok;
  logic                             train_en;
  logic                             unused_inputs;

  // Only the word-index bits and the counter MSBs matter here.
  assign unused_inputs = ^{pc, pc_ex, HP_count, LP_count};

  assign rd_idx = pc[CHOOSER_INDEX_WIDTH+1:2];
  assign wr_idx = pc_ex[CHOOSER_INDEX_WIDTH+1:2];

  assign hp_msb        = HP_count[JUMP_STATUS_COUNTER_WIDTH-1];
  assign lp_msb        = LP_count[JUMP_STATUS_COUNTER_WIDTH-1];
  assign sel_if        = rd_entry[CHOOSER_COUNTER_WIDTH-1];
  assign predict_taken = sel_if ? hp_msb : lp_msb;

  assign if_s = '{hp_taken: hp_msb, lp_taken: lp_msb, sel: sel_if,
                  pred: predict_taken, valid: 1'b1};

  chooser_table #(
    .INDEX_WIDTH  (CHOOSER_INDEX_WIDTH),
    .COUNTER_WIDTH(CHOOSER_COUNTER_WIDTH),
    .INIT_VALUE   (CHOOSER_INIT_VALUE)
  ) u_table (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_idx (rd_idx),
    .rd_data(rd_entry),
    .wr_en  (train_en),
    .wr_idx (wr_idx),
    .wr_up  (hp_ok)
  );

  // The later flush assignment overrides the valid bits loaded or held above,
  // so a flush wins over both advance and stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q <= '0;
      ex_q <= '0;
    end else begin
      if (!PL_stall) begin
        id_q <= if_s;
        ex_q <= id_q;
      end
      if (flush) begin
        id_q.valid <= 1'b0;
        ex_q.valid <= 1'b0;
      end
    end
  end

  assign predict_taken_ex = ex_q.pred;
  assign select_hp_ex     = ex_q.sel;

  assign ex_active     = resolve_en && ex_q.valid;
  assign mispredict_ex = ex_active && (ex_q.pred != branch_taken);

  // Move the chooser only when exactly one predictor was right; flush does
  // not suppress training of the entry currently in EX.
  assign hp_ok    = (ex_q.hp_taken == branch_taken);
  assign lp_ok    = (ex_q.lp_taken == branch_taken);
  assign train_en = ex_active && !PL_stall && (hp_ok != lp_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_cnt <= '0;
    end else if (mispredict_ex && !PL_stall) begin
      mispredict_cnt <= 16'(sat_step(SAT_W'(mispredict_cnt), 1'b1, 16));
    end
  end

endmodule

// File: tb/tb_prediction_chooser.sv
// tb/tb_prediction_chooser.sv - directed scoreboard bench for prediction_chooser
module tb_prediction_chooser;

  localparam logic [31:0] PC_A = 32'h0000_0010;

  localparam int S_PT  = 0;
  localparam int S_PTE = 1;
  localparam int S_SHE = 2;
  localparam int S_MIS = 3;
  localparam int S_CNT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PL_stall;
  logic        flush;
  logic [31:0] pc;
  logic [31:0] pc_ex;
  logic [1:0]  HP_count;
  logic [1:0]  LP_count;
  logic        resolve_en;
  logic        branch_taken;
  logic        predict_taken;
  logic        predict_taken_ex;
  logic        select_hp_ex;
  logic        mispredict_ex;
  logic [15:0] mispredict_cnt;

  typedef struct {
    string       tag;
    int          sig;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  prediction_chooser dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .PL_stall        (PL_stall),
    .flush           (flush),
    .pc              (pc),
    .pc_ex           (pc_ex),
    .HP_count        (HP_count),
    .LP_count        (LP_count),
    .resolve_en      (resolve_en),
    .branch_taken    (branch_taken),
    .predict_taken   (predict_taken),
    .predict_taken_ex(predict_taken_ex),
    .select_hp_ex    (select_hp_ex),
    .mispredict_ex   (mispredict_ex),
    .mispredict_cnt  (mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic want(input string tag, input int sig, input logic [15:0] v);
    sb.push_back('{tag, sig, v});
  endtask

  function automatic logic [15:0] probe(input int sig);
    case (sig)
      S_PT:    return {15'b0, predict_taken};
      S_PTE:   return {15'b0, predict_taken_ex};
      S_SHE:   return {15'b0, select_hp_ex};
      S_MIS:   return {15'b0, mispredict_ex};
      default: return mispredict_cnt;
    endcase
  endfunction

  task automatic sample();
    exp_t        e;
    logic [15:0] obs;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = probe(e.sig);
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; PL_stall = 1'b0; flush = 1'b0;
    pc = PC_A; pc_ex = PC_A; HP_count = 2'b11; LP_count = 2'b00;
    resolve_en = 1'b1; branch_taken = 1'b0;
    tick(); tick();
    want("rst_pred_hp", S_PT, 1); want("rst_pred_ex", S_PTE, 0);
    want("rst_sel_ex", S_SHE, 0); want("rst_mis_ex", S_MIS, 0);
    want("rst_cnt", S_CNT, 0);
    sample();
    HP_count = 2'b00; LP_count = 2'b11;
    want("rst_pred_weak_hp", S_PT, 0);
    sample();

    // c0: leave reset, branches predicted taken by HP
    HP_count = 2'b11; LP_count = 2'b00; resolve_en = 1'b0; rst_n = 1'b1;
    want("c0_pred", S_PT, 1);
    sample();
    tick();  // c1: EX still empty
    resolve_en = 1'b1; branch_taken = 1'b1;
    want("c1_mis_empty", S_MIS, 0); want("c1_pred_ex", S_PTE, 0);
    sample();
    tick();  // c2: first branch in EX, resolves not-taken
    branch_taken = 1'b0;
    want("c2_pred_ex", S_PTE, 1); want("c2_sel_ex", S_SHE, 1);
    want("c2_mis", S_MIS, 1);
    sample();
    tick();  // c3: entry 01 -> LP selected
    want("c3_cnt", S_CNT, 1); want("c3_pred_lp", S_PT, 0);
    want("c3_sel_ex", S_SHE, 1); want("c3_mis", S_MIS, 1);
    sample();
    tick();  // c4: entry 00, follows LP
    HP_count = 2'b00; LP_count = 2'b11;
    want("c4_cnt", S_CNT, 2); want("c4_pred_lp", S_PT, 1);
    want("c4_mis", S_MIS, 1);
    sample();
    tick();  // c5: entry held at 00, start stall with HP-only-right resolve
    PL_stall = 1'b1; branch_taken = 1'b1;
    want("c5_cnt", S_CNT, 3); want("c5_pred_sat0", S_PT, 1);
    want("c5_pred_ex", S_PTE, 0); want("c5_sel_ex", S_SHE, 0);
    want("c5_mis", S_MIS, 1);
    sample();
    for (int i = 0; i < 3; i++) begin
      tick();
      want("stall_cnt", S_CNT, 3); want("stall_pred", S_PT, 1);
      want("stall_pred_ex", S_PTE, 0); want("stall_sel_ex", S_SHE, 0);
      want("stall_mis", S_MIS, 1);
      sample();
    end
    PL_stall = 1'b0;
    tick();  // c9: first unstalled edge trained 00->01
    flush = 1'b1; PL_stall = 1'b1; resolve_en = 1'b0;
    want("c9_cnt", S_CNT, 4); want("c9_pred_ex", S_PTE, 1);
    want("c9_sel_ex", S_SHE, 0); want("c9_pred", S_PT, 1);
    sample();
    tick();  // c10: flushed EX must not act
    flush = 1'b0; PL_stall = 1'b0; resolve_en = 1'b1; branch_taken = 1'b0;
    want("c10_mis_flushed", S_MIS, 0); want("c10_cnt", S_CNT, 4);
    sample();
    tick();  // c11: no training happened, flushed ID bubble now in EX
    want("c11_cnt", S_CNT, 4); want("c11_pred", S_PT, 1);
    want("c11_mis_bubble", S_MIS, 0);
    sample();
    resolve_en = 1'b0;
    tick();  // c12: train 01->10 while IF reads the same index
    resolve_en = 1'b1; branch_taken = 1'b0;
    want("c12_collide_old", S_PT, 1); want("c12_sel_ex", S_SHE, 0);
    want("c12_mis", S_MIS, 1);
    sample();
    tick();  // c13: new entry 10 visible; train 10->11
    want("c13_collide_new", S_PT, 0); want("c13_cnt", S_CNT, 5);
    want("c13_sel_ex", S_SHE, 0); want("c13_mis", S_MIS, 1);
    sample();
    tick();  // c14: entry 11, HP-only-right again must saturate
    want("c14_pred", S_PT, 0); want("c14_cnt", S_CNT, 6);
    want("c14_sel_ex_old", S_SHE, 0); want("c14_mis", S_MIS, 1);
    sample();
    tick();  // c15: still 11; LP-only-right resolve steps 11->10
    branch_taken = 1'b1;
    want("c15_pred_sat_max", S_PT, 0); want("c15_cnt", S_CNT, 7);
    want("c15_sel_ex", S_SHE, 1); want("c15_pred_ex", S_PTE, 0);
    want("c15_mis", S_MIS, 1);
    sample();
    tick();  // c16: entry 10; step to 01
    want("c16_pred", S_PT, 0); want("c16_cnt", S_CNT, 8);
    want("c16_sel_ex", S_SHE, 1); want("c16_mis", S_MIS, 1);
    sample();
    tick();  // c17: entry 01, LP selected
    resolve_en = 1'b0;
    want("c17_pred", S_PT, 1); want("c17_cnt", S_CNT, 9);
    sample();

    // asynchronous reset mid-cycle restores table and counter
    #2 rst_n = 1'b0;
    want("mid_rst_cnt", S_CNT, 0); want("mid_rst_pred_ex", S_PTE, 0);
    want("mid_rst_sel_ex", S_SHE, 0); want("mid_rst_mis", S_MIS, 0);
    want("mid_rst_entry_hp", S_PT, 0);
    sample();
    HP_count = 2'b11; LP_count = 2'b00;
    want("mid_rst_pred_hp", S_PT, 1);
    sample();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
